bullet_pool: RTL and testbench

Parametrised pool of NUM_SLOTS independent projectiles. Each slot has its own position and signed per-tick velocity, is moved and bounds-culled on every game tick, and is collision-tested against one target (the player or the boss). It replaces fixed-count per-source bullet logic for enemy, boss and player shots, and exports flat position/active buses to the VGA renderer and a hit pulse to the life/score logic.

---
 rtl/bullet_pkg.sv | 23 ++
 rtl/bullet_pool_if.sv | 32 +++
 rtl/bullet_slot.sv | 132 +++++++++++++
 rtl/bullet_pool.sv | 140 ++++++++++++++
 tb/tb_bullet_pool.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bullet_pkg.sv
// -----------------------------------------------------------------------------
// bullet_pkg
// Shared defaults and helpers for the bullet pool.
//   DEF_COORD_W / DEF_VEL_W       : default coordinate and velocity widths
//   DEF_SCREEN_W / DEF_SCREEN_H   : default playfield bounds (exclusive)
//   coord_t / vel_t               : pixel coordinate and signed per-tick velocity
//   abs_diff()                    : |a - b| used by the hit/graze box tests
// -----------------------------------------------------------------------------
package bullet_pkg;

  localparam int DEF_COORD_W  = 10;
  localparam int DEF_VEL_W    = 4;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef logic        [DEF_COORD_W-1:0] coord_t;
  typedef logic signed [DEF_VEL_W-1:0]   vel_t;

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// -----------------------------------------------------------------------------
// bullet_pool_if
// Spawn handshake into the bullet pool.
//   spawn_valid        : source requests a new bullet
//   spawn_ready        : pool has a free slot and is not being flushed
//   spawn_x / spawn_y  : spawn position
//   spawn_vx/spawn_vy  : signed per-tick velocity (two's complement)
// Modports: master = bullet source, slave = bullet_pool.
// -----------------------------------------------------------------------------
interface bullet_pool_if #(
  parameter int COORD_W = bullet_pkg::DEF_COORD_W,
  parameter int VEL_W   = bullet_pkg::DEF_VEL_W
) ();

  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic [VEL_W-1:0]   spawn_vx;
  logic [VEL_W-1:0]   spawn_vy;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_vx, spawn_vy,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_vx, spawn_vy,
    output spawn_ready
  );

endinterface

// File: rtl/bullet_slot.sv
// -----------------------------------------------------------------------------
// bullet_slot
// One projectile: position/velocity registers, per-tick move, bounds cull and
// square hit-box compare against the target.
//   clk, rst              : clock, asynchronous active-high reset
//   i_tick                : game step strobe
//   i_clear               : flush (drops the live flag)
//   i_load, i_x..i_vy     : load a new bullet into this slot
//   i_target_x/y, _en     : collision target centre and enable
//   o_active, o_x, o_y    : live flag and current position
//   o_hit                 : combinational, this slot collides on this tick
//   o_graze               : (BULLET_POOL_GRAZE_EN) first near-miss this life
// Optional: `define BULLET_POOL_GRAZE_EN adds GRAZE_RADIUS and o_graze.
// -----------------------------------------------------------------------------
module bullet_slot #(
  parameter int COORD_W    = 10,
  parameter int VEL_W      = 4,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int HIT_RADIUS = 8
`ifdef BULLET_POOL_GRAZE_EN
  , parameter int GRAZE_RADIUS = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [VEL_W-1:0]   i_vx,
  input  logic [VEL_W-1:0]   i_vy,
  input  logic [COORD_W-1:0] i_target_x,
  input  logic [COORD_W-1:0] i_target_y,
  input  logic               i_target_en,
  output logic               o_active,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_hit
`ifdef BULLET_POOL_GRAZE_EN
  , output logic             o_graze
`endif
);

  import bullet_pkg::*;

  localparam int EXT_W = COORD_W + 1 - VEL_W;
  localparam logic signed [COORD_W:0] W_BOUND = (COORD_W+1)'(SCREEN_W);
  localparam logic signed [COORD_W:0] H_BOUND = (COORD_W+1)'(SCREEN_H);

  logic               r_active;
  logic [COORD_W-1:0] r_x, r_y;
  logic [VEL_W-1:0]   r_vx, r_vy;

  logic signed [COORD_W:0] w_vx_ext, w_vy_ext, w_nx, w_ny;
  logic                    w_oob, w_step, w_in_hit_box, w_hit;
  int                      w_dx, w_dy;

  // Candidate position one bit wider and signed, so stepping off the left/top
  // edge shows up as a negative value instead of wrapping.
  assign w_vx_ext = $signed({{EXT_W{r_vx[VEL_W-1]}}, r_vx});
  assign w_vy_ext = $signed({{EXT_W{r_vy[VEL_W-1]}}, r_vy});
  assign w_nx     = $signed({1'b0, r_x}) + w_vx_ext;
  assign w_ny     = $signed({1'b0, r_y}) + w_vy_ext;

  assign w_oob = w_nx[COORD_W] || (w_nx >= W_BOUND) ||
                 w_ny[COORD_W] || (w_ny >= H_BOUND);

  assign w_dx = abs_diff(int'(w_nx), int'(i_target_x));
  assign w_dy = abs_diff(int'(w_ny), int'(i_target_y));

  assign w_in_hit_box = (w_dx < HIT_RADIUS) && (w_dy < HIT_RADIUS);

  // A slot that is being loaded this cycle is, by construction, inactive, so
  // gating with i_load only documents that a fresh bullet never moves/collides.
  assign w_step = i_tick & r_active & ~i_clear & ~i_load;
  assign w_hit  = w_step & ~w_oob & i_target_en & w_in_hit_box;

`ifdef BULLET_POOL_GRAZE_EN
  logic r_grazed;
  logic w_graze;

  assign w_graze = w_step & ~w_oob & i_target_en & ~w_in_hit_box & ~r_grazed &
                   (w_dx < GRAZE_RADIUS) & (w_dy < GRAZE_RADIUS);
  assign o_graze = w_graze;
`endif

  // NOTE: every register, including the position/velocity payload, is reset so
  // the exported buses are defined straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so all slots and the
      // top-level flags update together from the same pre-edge values.
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
`ifdef BULLET_POOL_GRAZE_EN
      r_grazed <= 1'b0;
`endif
    end else if (i_clear) begin
      r_active <= 1'b0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_x      <= i_x;
      r_y      <= i_y;
      r_vx     <= i_vx;
      r_vy     <= i_vy;
`ifdef BULLET_POOL_GRAZE_EN
      r_grazed <= 1'b0;
`endif
    end else if (w_step) begin
      if (w_oob || w_hit) r_active <= 1'b0;
      // An off-screen bullet keeps its last on-screen position.
      if (!w_oob) begin
        r_x <= w_nx[COORD_W-1:0];
        r_y <= w_ny[COORD_W-1:0];
      end
`ifdef BULLET_POOL_GRAZE_EN
      if (w_graze) r_grazed <= 1'b1;
`endif
    end
  end

  assign o_active = r_active;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_hit    = w_hit;

endmodule

// File: rtl/bullet_pool.sv
// -----------------------------------------------------------------------------
// bullet_pool
// Pool of NUM_SLOTS independent projectiles moved on each game tick, culled at
// the screen edges and collision-tested against a single target.
//   clk, rst         : clock, asynchronous active-high reset
//   i_tick           : one-cycle game-step strobe
//   i_clear          : flush all slots, refuse spawns
//   spawn_if         : spawn handshake (bullet_pool_if.slave)
//   i_target_x/y     : target centre; i_target_en gates collisions
//   o_active         : per-slot live flags
//   o_pos_x/o_pos_y  : flat position buses, slot i at [i*COORD_W +: COORD_W]
//   o_hit            : registered one-cycle pulse when any slot collides
//   o_live_count     : number of live slots
//   o_graze          : (BULLET_POOL_GRAZE_EN) registered near-miss pulse
// Optional: `define BULLET_POOL_GRAZE_EN adds GRAZE_RADIUS and o_graze.
// -----------------------------------------------------------------------------
module bullet_pool #(
  parameter int NUM_SLOTS  = 12,
  parameter int COORD_W    = bullet_pkg::DEF_COORD_W,
  parameter int VEL_W      = bullet_pkg::DEF_VEL_W,
  parameter int SCREEN_W   = bullet_pkg::DEF_SCREEN_W,
  parameter int SCREEN_H   = bullet_pkg::DEF_SCREEN_H,
  parameter int HIT_RADIUS = 8
`ifdef BULLET_POOL_GRAZE_EN
  , parameter int GRAZE_RADIUS = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_tick,
  input  logic                           i_clear,
  bullet_pool_if.slave                   spawn_if,
  input  logic [COORD_W-1:0]             i_target_x,
  input  logic [COORD_W-1:0]             i_target_y,
  input  logic                           i_target_en,
  output logic [NUM_SLOTS-1:0]           o_active,
  output logic [NUM_SLOTS*COORD_W-1:0]   o_pos_x,
  output logic [NUM_SLOTS*COORD_W-1:0]   o_pos_y,
  output logic                           o_hit,
  output logic [$clog2(NUM_SLOTS+1)-1:0] o_live_count
`ifdef BULLET_POOL_GRAZE_EN
  , output logic                         o_graze
`endif
);

  import bullet_pkg::*;

  localparam int LC_W = $clog2(NUM_SLOTS+1);

  logic                 w_accept;
  logic [NUM_SLOTS-1:0] w_load;
  logic [NUM_SLOTS-1:0] w_slot_hit;
  logic                 r_hit;
`ifdef BULLET_POOL_GRAZE_EN
  logic [NUM_SLOTS-1:0] w_slot_graze;
  logic                 r_graze;
`endif

  // Ready is held low during reset even though the pool is empty then.
  assign spawn_if.spawn_ready = ~rst & ~i_clear & ~(&o_active);
  assign w_accept             = spawn_if.spawn_valid & spawn_if.spawn_ready;

  // Lowest-index free slot takes the spawn.
  always_comb begin
    logic found;
    // NOTE: defaults first so every path assigns every bit and no latch forms.
    w_load = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!o_active[i] && !found) begin
        w_load[i] = w_accept;
        found     = 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      bullet_slot #(
        .COORD_W      (COORD_W),
        .VEL_W        (VEL_W),
        .SCREEN_W     (SCREEN_W),
        .SCREEN_H     (SCREEN_H),
        .HIT_RADIUS   (HIT_RADIUS)
`ifdef BULLET_POOL_GRAZE_EN
        , .GRAZE_RADIUS (GRAZE_RADIUS)
`endif
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_clear     (i_clear),
        .i_load      (w_load[g]),
        .i_x         (spawn_if.spawn_x),
        .i_y         (spawn_if.spawn_y),
        .i_vx        (spawn_if.spawn_vx),
        .i_vy        (spawn_if.spawn_vy),
        .i_target_x  (i_target_x),
        .i_target_y  (i_target_y),
        .i_target_en (i_target_en),
        .o_active    (o_active[g]),
        .o_x         (o_pos_x[g*COORD_W +: COORD_W]),
        .o_y         (o_pos_y[g*COORD_W +: COORD_W]),
        .o_hit       (w_slot_hit[g])
`ifdef BULLET_POOL_GRAZE_EN
        , .o_graze   (w_slot_graze[g])
`endif
      );
    end
  endgenerate

  // Slot-level hit/graze are already suppressed by clear, so a flush cycle
  // can never raise these pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= 1'b0;
`ifdef BULLET_POOL_GRAZE_EN
      r_graze <= 1'b0;
`endif
    end else begin
      r_hit <= |w_slot_hit;
`ifdef BULLET_POOL_GRAZE_EN
      r_graze <= |w_slot_graze;
`endif
    end
  end

  assign o_hit = r_hit;
`ifdef BULLET_POOL_GRAZE_EN
  assign o_graze = r_graze;
`endif

  always_comb begin
    o_live_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      o_live_count = o_live_count + LC_W'(o_active[i]);
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_bullet_pool
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a slot-array model of the pool.
// Optional: `define BULLET_POOL_GRAZE_EN also checks the graze pulse.
// -----------------------------------------------------------------------------
module tb_bullet_pool;

  import bullet_pkg::*;

  localparam int N  = 12;
  localparam int CW = 10;
  localparam int VW = 4;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int HR = 8;
  localparam int GR = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick, clr, ten;
  coord_t tx, ty;

  logic [N-1:0]    active;
  logic [N*CW-1:0] pos_x, pos_y;
  logic            hit;
  logic [3:0]      live_count;
`ifdef BULLET_POOL_GRAZE_EN
  logic            graze;
`endif

  bullet_pool_if #(.COORD_W(CW), .VEL_W(VW)) sif ();

  bullet_pool #(.NUM_SLOTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (tick),
    .i_clear      (clr),
    .spawn_if     (sif),
    .i_target_x   (tx),
    .i_target_y   (ty),
    .i_target_en  (ten),
    .o_active     (active),
    .o_pos_x      (pos_x),
    .o_pos_y      (pos_y),
    .o_hit        (hit),
    .o_live_count (live_count)
`ifdef BULLET_POOL_GRAZE_EN
    , .o_graze    (graze)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: array of bullets ----------------
  bit m_act[N];
  int m_x[N], m_y[N], m_vx[N], m_vy[N];
  bit m_grazed[N];
  bit m_hit, m_graze;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step();
    int slot, nx, ny, dx, dy;
    bit hit_n, graze_n;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_grazed[i] = 0;
      end
      m_hit = 0; m_graze = 0;
      return;
    end
    hit_n = 0; graze_n = 0;
    if (clr) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
    end else begin
      slot = -1;
      for (int i = 0; i < N; i++) if (!m_act[i] && slot < 0) slot = i;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (m_act[i]) begin
            nx = m_x[i] + m_vx[i];
            ny = m_y[i] + m_vy[i];
            if (nx < 0 || nx >= SW || ny < 0 || ny >= SH) begin
              m_act[i] = 0;
            end else begin
              m_x[i] = nx; m_y[i] = ny;
              dx = iabs(nx - int'(tx)); dy = iabs(ny - int'(ty));
              if (ten && dx < HR && dy < HR) begin
                m_act[i] = 0; hit_n = 1;
              end else if (ten && dx < GR && dy < GR && !m_grazed[i]) begin
                m_grazed[i] = 1; graze_n = 1;
              end
            end
          end
        end
      end
      if (sif.spawn_valid && slot >= 0) begin
        m_act[slot]    = 1;
        m_x[slot]      = int'(sif.spawn_x);
        m_y[slot]      = int'(sif.spawn_y);
        m_vx[slot]     = int'($signed(sif.spawn_vx));
        m_vy[slot]     = int'($signed(sif.spawn_vy));
        m_grazed[slot] = 0;
      end
    end
    m_hit = hit_n; m_graze = graze_n;
  endtask

  always @(posedge clk or posedge rst) model_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt += int'(m_act[i]);
      check($sformatf("active[%0d]", i), 64'(active[i]), 64'(m_act[i]));
      if (m_act[i]) begin
        check($sformatf("pos_x[%0d]", i), 64'(pos_x[i*CW +: CW]), 64'(m_x[i]));
        check($sformatf("pos_y[%0d]", i), 64'(pos_y[i*CW +: CW]), 64'(m_y[i]));
      end
    end
    check("live_count", 64'(live_count), 64'(cnt));
    check("hit", 64'(hit), 64'(m_hit));
    check("spawn_ready", 64'(sif.spawn_ready), 64'(!rst && !clr && cnt < N));
`ifdef BULLET_POOL_GRAZE_EN
    check("graze", 64'(graze), 64'(m_graze));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic spawn(input int x, input int y, input int vx, input int vy);
    sif.spawn_valid = 1'b1;
    sif.spawn_x  = CW'(x);
    sif.spawn_y  = CW'(y);
    sif.spawn_vx = VW'(vx);
    sif.spawn_vy = VW'(vy);
    cyc();
    sif.spawn_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  function automatic int px(input int i);
    return int'(pos_x[i*CW +: CW]);
  endfunction

  function automatic int py(input int i);
    return int'(pos_y[i*CW +: CW]);
  endfunction

  initial begin
    tick = 0; clr = 0; ten = 0; tx = '0; ty = '0;
    sif.spawn_valid = 0; sif.spawn_x = '0; sif.spawn_y = '0;
    sif.spawn_vx = '0; sif.spawn_vy = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("ready_in_reset", 64'(sif.spawn_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    #3;
    check("reset_active", 64'(active), 64'd0);
    check("reset_live", 64'(live_count), 64'd0);
    check("reset_hit", 64'(hit), 64'd0);
    check("reset_ready", 64'(sif.spawn_ready), 64'd1);

    // First bullet and three ticks of motion.
    spawn(100, 100, 2, -3); #3;
    check("first_active", 64'(active), 64'd1);
    check("first_live", 64'(live_count), 64'd1);
    repeat (3) do_tick();
    #3;
    check("move3_x", 64'(px(0)), 64'd106);
    check("move3_y", 64'(py(0)), 64'd91);

    // Fill the pool; slot 5 sits on the right edge moving right.
    do_clear();
    for (int i = 0; i < N; i++) begin
      if (i == 5) spawn(639, 10, 1, 0);
      else        spawn(20 + 40 * i, 50, 0, 0);
    end
    #3;
    check("full_ready", 64'(sif.spawn_ready), 64'd0);
    spawn(1, 1, 0, 0); #3;
    check("full_ignore", 64'(live_count), 64'd12);
    do_tick(); #3;
    check("cull5_active", 64'(active), 64'hFDF);
    check("cull5_ready", 64'(sif.spawn_ready), 64'd1);
    spawn(200, 200, 0, 0); #3;
    check("refill_active", 64'(active), 64'hFFF);
    check("refill_x5", 64'(px(5)), 64'd200);

    // Edge culls and a just-inside survivor.
    do_clear();
    spawn(2, 240, -3, 0); do_tick(); #3;
    check("cull_left", 64'(live_count), 64'd0);
    spawn(637, 240, 3, 0); do_tick(); #3;
    check("cull_right", 64'(live_count), 64'd0);
    spawn(636, 479, 3, 0); do_tick(); #3;
    check("edge_survive", 64'(live_count), 64'd1);
    check("edge_x", 64'(px(0)), 64'd639);

    // Double collision gives one hit pulse.
    do_clear();
    tx = 320; ty = 240; ten = 1;
    spawn(323, 240, 2, 0);
    spawn(316, 246, 2, -2);
    do_tick(); #3;
    check("dbl_hit", 64'(hit), 64'd1);
    check("dbl_live", 64'(live_count), 64'd0);
    cyc(); #3;
    check("hit_one_cycle", 64'(hit), 64'd0);
    ten = 0;
    spawn(323, 240, 2, 0);
    spawn(316, 246, 2, -2);
    do_tick(); #3;
    check("noen_hit", 64'(hit), 64'd0);
    check("noen_live", 64'(live_count), 64'd2);
    check("noen_x0", 64'(px(0)), 64'd325);
    check("noen_y1", 64'(py(1)), 64'd244);
    do_clear();
    ten = 1;
    spawn(328, 240, 0, 0); do_tick(); #3;
    check("box_edge_hit", 64'(hit), 64'd0);
    check("box_edge_live", 64'(live_count), 64'd1);

    // Spawn and tick in the same cycle.
    do_clear();
    ten = 0;
    spawn(50, 50, 1, 1);
    sif.spawn_valid = 1; sif.spawn_x = 400; sif.spawn_y = 300;
    sif.spawn_vx = 4'd5; sif.spawn_vy = 4'd5; tick = 1;
    cyc();
    sif.spawn_valid = 0; tick = 0; #3;
    check("st_new_x", 64'(px(1)), 64'd400);
    check("st_new_y", 64'(py(1)), 64'd300);
    check("st_old_x", 64'(px(0)), 64'd51);

    // Clear beats spawn.
    sif.spawn_valid = 1; sif.spawn_x = 10; sif.spawn_y = 10; clr = 1;
    cyc();
    sif.spawn_valid = 0; clr = 0; #3;
    check("clr_spawn_active", 64'(active), 64'd0);

    // Asynchronous reset mid-flight.
    spawn(100, 100, 1, 1); spawn(200, 200, -1, -1);
    tick = 1; ten = 1; tx = 101; ty = 101;
    @(posedge clk); #2 rst = 1'b1; #1;
    check("rst_active", 64'(active), 64'd0);
    check("rst_live", 64'(live_count), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_ready", 64'(sif.spawn_ready), 64'd0);
    tick = 0; ten = 0;
    @(posedge clk); #1 rst = 1'b0;

`ifdef BULLET_POOL_GRAZE_EN
    tx = 320; ty = 240; ten = 1;
    spawn(334, 240, -2, 0);
    do_tick(); #3;
    check("graze_first", 64'(graze), 64'd1);
    do_tick(); #3;
    check("graze_once", 64'(graze), 64'd0);
    check("graze_alive", 64'(live_count), 64'd1);
    ten = 0;
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        tx = CW'($urandom_range(100, 540));
        ty = CW'($urandom_range(100, 380));
      end
      ten  = ($urandom_range(0, 3) != 0);
      tick = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      sif.spawn_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) begin
        sif.spawn_x = CW'(int'(tx) + $urandom_range(0, 40) - 20);
        sif.spawn_y = CW'(int'(ty) + $urandom_range(0, 40) - 20);
      end else begin
        sif.spawn_x = CW'($urandom_range(0, SW - 1));
        sif.spawn_y = CW'($urandom_range(0, SH - 1));
      end
      sif.spawn_vx = VW'($urandom_range(0, 15));
      sif.spawn_vy = VW'($urandom_range(0, 15));
      cyc();
    end
    sif.spawn_valid = 0; tick = 0; clr = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
